// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - instruction memory fetch responder with fixed-latency pipeline and in-order response FIFO
// Optional statistics counters (stat_req_cnt, stat_fault_cnt, stat_drop_cnt): define IMEM_STATS_EN
module imem_fetch_responder #(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_fault,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0] stat_req_cnt,
    output logic [15:0] stat_fault_cnt,
    output logic [15:0] stat_drop_cnt
`endif
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          PTR_W      = $clog2(MAX_OUTSTANDING);
    localparam int          CNT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    // Program memory (contents survive reset)
    logic [31:0]      r_mem [DEPTH_WORDS];

    // Fetch pipeline stages
    logic             r_pv [LATENCY];
    logic [31:0]      r_pa [LATENCY];
    logic [31:0]      r_pi [LATENCY];
    logic             r_pf [LATENCY];

    // Response FIFO
    logic [31:0]      r_fa [MAX_OUTSTANDING];
    logic [31:0]      r_fi [MAX_OUTSTANDING];
    logic             r_ff [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_fifo_cnt;

    // Accepted requests not yet consumed (pipeline + FIFO)
    logic [CNT_W-1:0] r_out_cnt;

    logic             w_req_fault;
    logic [IDX_W-1:0] w_req_idx;
    logic [31:0]      w_rd_instr;
    logic             w_wr_ok;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_not_full;

    assign w_req_idx   = req_addr[IDX_W+1:2];
    assign w_wr_idx    = wr_addr[IDX_W+1:2];
    assign w_req_fault = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
    assign w_wr_ok     = wr_en && (wr_addr < ADDR_LIMIT);
    assign w_not_full  = (r_out_cnt < CNT_W'(MAX_OUTSTANDING));

    // Faulting fetches never touch the array and return a NOP
    assign w_rd_instr  = w_req_fault ? NOP_INSTR : r_mem[w_req_idx];

    // Reset holds ready low combinationally so nothing is taken while rst is high
    assign req_ready   = !rst && !flush && w_not_full;
    assign w_accept    = req_valid && req_ready;
    assign w_push      = r_pv[LATENCY-1];
    assign rsp_valid   = (r_fifo_cnt != '0);
    assign w_pop       = rsp_valid && rsp_ready;

    // Response outputs read zero whenever the FIFO is empty, including during reset
    assign rsp_instr   = rsp_valid ? r_fi[r_rd_ptr] : 32'h0;
    assign rsp_addr    = rsp_valid ? r_fa[r_rd_ptr] : 32'h0;
    assign rsp_fault   = rsp_valid ? r_ff[r_rd_ptr] : 1'b0;

    // Program-load write; the read for an accepted request samples the old word
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    // Advance the fetch pipeline one stage per cycle; flush kills every valid bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= 32'h0;
                r_pi[i] <= 32'h0;
                r_pf[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pv[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pa[0] <= req_addr;
            r_pi[0] <= w_rd_instr;
            r_pf[0] <= w_req_fault;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pi[i] <= r_pi[i-1];
                r_pf[i] <= r_pf[i-1];
            end
        end
    end

    // FIFO payload storage, written at the tail when the last stage retires
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_fa[r_wr_ptr] <= r_pa[LATENCY-1];
            r_fi[r_wr_ptr] <= r_pi[LATENCY-1];
            r_ff[r_wr_ptr] <= r_pf[LATENCY-1];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
            end
        end
    end

    // Outstanding count bounds pipeline plus FIFO occupancy, so the FIFO cannot overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_cnt <= '0;
        end else if (flush) begin
            r_out_cnt <= '0;
        end else if (w_accept && !w_pop) begin
            r_out_cnt <= r_out_cnt + 1'b1;
        end else if (w_pop && !w_accept) begin
            r_out_cnt <= r_out_cnt - 1'b1;
        end
    end

`ifdef IMEM_STATS_EN
    logic [31:0] r_stat_req;
    logic [15:0] r_stat_fault;
    logic [15:0] r_stat_drop;
    logic [16:0] w_drop_sum;

    assign w_drop_sum     = {1'b0, r_stat_drop} + 17'(r_out_cnt);
    assign stat_req_cnt   = r_stat_req;
    assign stat_fault_cnt = r_stat_fault;
    assign stat_drop_cnt  = r_stat_drop;

    // Saturating activity counters; flush adds the discarded entries but never clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_req   <= '0;
            r_stat_fault <= '0;
            r_stat_drop  <= '0;
        end else begin
            if (w_accept && (r_stat_req != '1)) begin
                r_stat_req <= r_stat_req + 1'b1;
            end
            if (w_accept && w_req_fault && (r_stat_fault != '1)) begin
                r_stat_fault <= r_stat_fault + 1'b1;
            end
            if (flush) begin
                r_stat_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - randomized self-checking bench for imem_fetch_responder against a queue model
module tb_imem_fetch_responder;

    localparam int          LAT   = 2;
    localparam int          MAXO  = 4;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_fault;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
`ifdef IMEM_STATS_EN
    logic [31:0] stat_req_cnt;
    logic [15:0] stat_fault_cnt;
    logic [15:0] stat_drop_cnt;
`endif

    always #5 clk = ~clk;

    imem_fetch_responder #(
        .DEPTH_WORDS    (DEPTH),
        .LATENCY        (LAT),
        .MAX_OUTSTANDING(MAXO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
`ifdef IMEM_STATS_EN
        ,
        .stat_req_cnt  (stat_req_cnt),
        .stat_fault_cnt(stat_fault_cnt),
        .stat_drop_cnt (stat_drop_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
        int          t;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mmem [16];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          m_req = 0;
    int          m_fault = 0;
    int          m_drop = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model
    task automatic step(input logic v, input logic [31:0] a, input logic f, input logic rr,
                        input logic we, input logic [31:0] wa, input logic [31:0] wd);
        bit   exp_ready;
        bit   exp_valid;
        bit   acc;
        bit   pop;
        rsp_t e;
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        flush     = f;
        rsp_ready = rr;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        #1;
        exp_ready = !f && (q.size() < MAXO);
        exp_valid = (q.size() > 0) && (q[0].t <= cyc);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("rsp_instr", rsp_instr, q[0].instr);
            check("rsp_addr", rsp_addr, q[0].addr);
            check("rsp_fault", 32'(rsp_fault), 32'(q[0].fault));
        end
        acc = v && exp_ready;
        pop = exp_valid && rr;
        @(posedge clk);
        cyc++;
        if (f) begin
            m_drop += q.size();
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.addr  = a;
                e.fault = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
                e.instr = e.fault ? NOP : mmem[a[5:2]];
                e.t     = cyc + LAT;
                q.push_back(e);
                m_req++;
                if (e.fault) m_fault++;
            end
        end
        if (we && (wa < 32'h40)) mmem[wa[5:2]] = wd;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, rr, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        else if (r == 7) return {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
        else if (r == 8) return 32'h1000 + 32'(4 * $urandom_range(0, 3));
        else return 32'hFFFF_FFFC;
    endfunction

    initial begin
        logic [31:0] w;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_instr", rsp_instr, 32'h0);
        check("reset_rsp_addr", rsp_addr, 32'h0);
        check("reset_rsp_fault", 32'(rsp_fault), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Preload the low 16 words
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            if (i == 0) w = 32'h0050_0093;
            if (i == 1) w = 32'h00A0_0113;
            if (i == 4) w = NOP;
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'(4 * i), w);
        end

        // Back-to-back fetch of two loaded words
        step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(4, 1'b1);

        // Back-pressure: four accepts then stall, head held
        for (int i = 0; i < 8; i++) step(1'b1, 32'(4 * (i % 4)), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(8, 1'b1);

        // Misaligned and out-of-range faults
        step(1'b1, 32'h2, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h1000, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(4, 1'b1);

        // Flush with three in flight, then a clean fetch
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(4, 1'b1);

        // Same-cycle write and read of one word returns the old value
        step(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        idle(3, 1'b1);
        step(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(3, 1'b1);

        // Out-of-range write must not alias into word 0
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h1234_5678);
        step(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(3, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] wa;
            wa = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 63))
                                             : 32'($urandom_range(0, 63));
            step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, wa, $urandom);
        end
        idle(8, 1'b1);

`ifdef IMEM_STATS_EN
        check("stat_req_cnt", stat_req_cnt, 32'(m_req));
        check("stat_fault_cnt", 32'(stat_fault_cnt), 32'(m_fault));
        check("stat_drop_cnt", 32'(stat_drop_cnt), 32'(m_drop));
`endif

        // Asynchronous reset with two responses queued
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(3, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        wr_en     = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("arst_rsp_instr", rsp_instr, 32'h0);
        check("arst_rsp_addr", rsp_addr, 32'h0);
        check("arst_rsp_fault", 32'(rsp_fault), 32'h0);
        check("arst_req_ready", 32'(req_ready), 32'h0);
`ifdef IMEM_STATS_EN
        check("arst_stat_req", stat_req_cnt, 32'h0);
        check("arst_stat_fault", 32'(stat_fault_cnt), 32'h0);
        check("arst_stat_drop", 32'(stat_drop_cnt), 32'h0);
`endif
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
